cat_rec_sequencer: RTL

Sequencer and memory-port arbiter for the cat recognizer engine. Once started, it walks the image words and their weights in the shared memory and accumulates the weighted sum. It then compares the sum against zero and drives `CatRecOut`. It shares the single memory read port between the engine and the host register/APB read path.

---
 rtl/cat_rec_pkg.sv | 37 +++
 rtl/mem_port_arbiter.sv | 50 +++++
 rtl/cat_rec_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cat_rec_pkg.sv
// rtl/cat_rec_pkg.sv - shared types, widths and field helpers for the cat recognizer sequencer
// Purpose: state enum, accumulator width function, pixel/weight field extraction.
// Ports: none (package).
package cat_rec_pkg;

  localparam int WEIGHT_BASE_DEFAULT = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_PIX,
    ST_RD_W,
    ST_MAC,
    ST_DECIDE
  } seq_state_t;

  // 8b pixel x weight product, +2 bits for the 3-term sum, +addr bits for the word count
  function automatic int calc_acc_w(input int weight_precision, input int addr_depth);
    return 8 + weight_precision + 2 + addr_depth;
  endfunction

  function automatic logic [7:0] get_pixel(input logic [63:0] word, input int idx);
    return word[8*idx +: 8];
  endfunction

  // Signed weight field idx of width wp, sign-extended to 16 bits
  function automatic logic signed [15:0] get_weight(input logic [63:0] word, input int idx,
                                                    input int wp);
    logic [63:0] shifted;
    logic [15:0] result;
    shifted = word >> (wp * idx);
    for (int b = 0; b < 16; b++) begin
      result[b] = (b < wp) ? shifted[b] : shifted[6'(wp - 1)];
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester alternating-priority arbiter for the shared read port
// Purpose: grants engine or host, muxes the address, tags the returning data beat.
// Ports: i_eng_req/i_eng_pix/i_eng_addr (engine), i_host_req/i_host_addr (host),
//        o_eng_gnt/o_host_gnt (grants), o_mem_req/o_mem_addr (memory port),
//        o_host_rvalid (host data beat), o_pix_load (engine pixel data beat).
module mem_port_arbiter #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_eng_req,
  input  logic              i_eng_pix,
  input  logic [ADDR_W-1:0] i_eng_addr,
  input  logic              i_host_req,
  input  logic [ADDR_W-1:0] i_host_addr,
  output logic              o_eng_gnt,
  output logic              o_host_gnt,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_host_rvalid,
  output logic              o_pix_load
);

  logic r_host_prio;  // 1: host wins the next conflict
  logic r_host_tag;
  logic r_pix_tag;
  logic w_conflict;

  assign w_conflict    = i_eng_req & i_host_req;
  assign o_host_gnt    = i_host_req & (~i_eng_req | r_host_prio);
  assign o_eng_gnt     = i_eng_req & ~o_host_gnt;
  assign o_mem_req     = i_eng_req | i_host_req;
  assign o_mem_addr    = o_host_gnt ? i_host_addr : i_eng_addr;
  assign o_host_rvalid = r_host_tag;
  assign o_pix_load    = r_pix_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_host_prio <= 1'b1;
      r_host_tag  <= 1'b0;
      r_pix_tag   <= 1'b0;
    end else begin
      // Priority only moves on a real conflict: the loser goes first next time
      if (w_conflict) r_host_prio <= ~o_host_gnt;
      r_host_tag <= o_host_gnt;
      r_pix_tag  <= o_eng_gnt & i_eng_pix;
    end
  end

endmodule

// File: rtl/cat_rec_sequencer.sv
// rtl/cat_rec_sequencer.sv - cat recognizer sequencer: walks pixels/weights, accumulates, decides
// Purpose: inference FSM plus shared memory port arbitration with the host read path.
// Ports: start/img_len/bias (run request), host_req/host_addr/host_gnt/host_rvalid/host_rdata
//        (host reads), mem_req/mem_addr/mem_rdata (memory port), busy/done/CatRecOut/acc_out.
module cat_rec_sequencer
  import cat_rec_pkg::*;
#(
  parameter int Amba_Word        = 24,
  parameter int Amba_Addr_Depth  = 13,
  parameter int Weight_precision = 5,
  parameter int Weight_base      = WEIGHT_BASE_DEFAULT,
  localparam int ACC_W           = calc_acc_w(Weight_precision, Amba_Addr_Depth)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [Amba_Addr_Depth-1:0] img_len,
  input  logic [Amba_Word-1:0]       bias,
  input  logic                       host_req,
  input  logic [Amba_Addr_Depth-1:0] host_addr,
  output logic                       host_gnt,
  output logic                       host_rvalid,
  output logic [Amba_Word-1:0]       host_rdata,
  output logic                       mem_req,
  output logic [Amba_Addr_Depth-1:0] mem_addr,
  input  logic [Amba_Word-1:0]       mem_rdata,
  output logic                       busy,
  output logic                       done,
  output logic                       CatRecOut,
  output logic signed [ACC_W-1:0]    acc_out
);

  seq_state_t                  r_state;
  logic [Amba_Addr_Depth-1:0]  r_len;
  logic [Amba_Addr_Depth-1:0]  r_k;
  logic signed [ACC_W-1:0]     r_acc;
  logic [2:0][7:0]             r_pix;

  logic                        w_eng_req;
  logic                        w_eng_pix;
  logic [Amba_Addr_Depth-1:0]  w_eng_addr;
  logic                        w_eng_gnt;
  logic                        w_pix_load;
  logic [Amba_Addr_Depth-1:0]  w_k_next;
  logic [63:0]                 w_rdata64;
  logic signed [15:0]          w_wgt [3];
  logic signed [ACC_W-1:0]     w_mac_sum;

  assign w_eng_pix  = (r_state == ST_RD_PIX);
  assign w_eng_req  = w_eng_pix | (r_state == ST_RD_W);
  assign w_eng_addr = w_eng_pix ? r_k : r_k + Amba_Addr_Depth'(Weight_base);
  assign w_k_next   = r_k + Amba_Addr_Depth'(1);
  assign w_rdata64  = {{(64 - Amba_Word){1'b0}}, mem_rdata};
  assign host_rdata = host_rvalid ? mem_rdata : '0;

  mem_port_arbiter #(
    .ADDR_W(Amba_Addr_Depth)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .i_eng_req    (w_eng_req),
    .i_eng_pix    (w_eng_pix),
    .i_eng_addr   (w_eng_addr),
    .i_host_req   (host_req),
    .i_host_addr  (host_addr),
    .o_eng_gnt    (w_eng_gnt),
    .o_host_gnt   (host_gnt),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .o_host_rvalid(host_rvalid),
    .o_pix_load   (w_pix_load)
  );

  // In MAC, mem_rdata carries the weight word granted in the last RD_W cycle
  always_comb begin
    w_mac_sum = '0;
    for (int i = 0; i < 3; i++) begin
      w_wgt[i]  = get_weight(w_rdata64, i, Weight_precision);
      w_mac_sum = w_mac_sum
                + ($signed({{(ACC_W - 8){1'b0}}, r_pix[i]})
                 * $signed({{(ACC_W - 16){w_wgt[i][15]}}, w_wgt[i]}));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_pix     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      CatRecOut <= 1'b0;
      acc_out   <= '0;
    end else begin
      done <= 1'b0;
      if (w_pix_load) begin
        for (int i = 0; i < 3; i++) r_pix[i] <= get_pixel(w_rdata64, i);
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len     <= img_len;
            r_k       <= '0;
            r_acc     <= {{(ACC_W - Amba_Word){bias[Amba_Word-1]}}, bias};
            CatRecOut <= 1'b0;
            acc_out   <= '0;
            busy      <= 1'b1;
            r_state   <= (img_len == '0) ? ST_DECIDE : ST_RD_PIX;
          end
        end
        ST_RD_PIX: if (w_eng_gnt) r_state <= ST_RD_W;
        ST_RD_W:   if (w_eng_gnt) r_state <= ST_MAC;
        ST_MAC: begin
          r_acc   <= r_acc + w_mac_sum;
          r_k     <= w_k_next;
          r_state <= (w_k_next == r_len) ? ST_DECIDE : ST_RD_PIX;
        end
        ST_DECIDE: begin
          CatRecOut <= ~r_acc[ACC_W-1] & (r_acc != '0);
          acc_out   <= r_acc;
          done      <= 1'b1;
          busy      <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
